alu_seq: RTL and testbench

Registered, handshaked successor to the combinational 16-bit ALU. It is parametrised in width and adds an iterative signed multiply mode and shift modes, all behind a valid/ready interface. Results and the `{overflow, negative, zero}` flags are held in output registers until the consumer accepts them. It sits between an operand-issue stage and a result-writeback stage in the datapath.

---
 rtl/alu_seq_if.sv | 31 +++
 rtl/alu_seq.sv | 191 +++++++++++++++++++
 tb/tb_alu_seq.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_if
// Description : Valid/ready request and result bundle for alu_seq.
//               slave = ALU side, master = producer/consumer side.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_seq_if #(
    parameter int BW = 16
);
    logic          in_valid;
    logic          in_ready;
    logic [BW-1:0] in_a;
    logic [BW-1:0] in_b;
    logic [3:0]    opcode;
    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] out;
    logic [2:0]    flags;

    modport slave (
        input  in_valid, in_a, in_b, opcode, out_ready,
        output in_ready, out_valid, out, flags
    );

    modport master (
        output in_valid, in_a, in_b, opcode, out_ready,
        input  in_ready, out_valid, out, flags
    );
endinterface
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Registered, handshaked ALU. Single-cycle arithmetic, logic
//               and shift ops; iterative signed shift-add multiply. Result
//               and {overflow, negative, zero} are held until accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq #(
    parameter int BW = 16
) (
    input  wire logic clk,
    input  wire logic rst,
    alu_seq_if.slave  bus
);
    localparam int c_sw = $clog2(BW);
    localparam logic [c_sw-1:0] c_cnt_last = c_sw'(BW - 1);
    localparam logic [BW-1:0]   c_one      = BW'(1);
    localparam logic [BW-1:0]   c_max_pos  = {1'b0, {(BW-1){1'b1}}};
    localparam logic [BW-1:0]   c_min_neg  = {1'b1, {(BW-1){1'b0}}};

    localparam logic [3:0] c_op_add = 4'd0;
    localparam logic [3:0] c_op_sub = 4'd1;
    localparam logic [3:0] c_op_and = 4'd2;
    localparam logic [3:0] c_op_or  = 4'd3;
    localparam logic [3:0] c_op_xor = 4'd4;
    localparam logic [3:0] c_op_not = 4'd5;
    localparam logic [3:0] c_op_inc = 4'd6;
    localparam logic [3:0] c_op_dec = 4'd7;
    localparam logic [3:0] c_op_sll = 4'd8;
    localparam logic [3:0] c_op_srl = 4'd9;
    localparam logic [3:0] c_op_sra = 4'd10;
    localparam logic [3:0] c_op_mul = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_live;       // low during reset and the edge it is released on
    logic            w_in_ready;
    logic            w_out_valid;
    logic            w_accept;

    logic [BW-1:0]   r_out;
    logic [2:0]      r_flags;
    logic [c_sw-1:0] r_cnt;
    logic            r_sign;
    logic [2*BW-1:0] r_acc;
    logic [2*BW-1:0] r_mcand;
    logic [BW-1:0]   r_mplier;

    logic [c_sw-1:0] w_sh;
    logic [BW-1:0]   w_res;
    logic            w_ovf;
    logic            w_a_msb;
    logic            w_b_msb;
    logic [BW-1:0]   w_abs_a;
    logic [BW-1:0]   w_abs_b;
    logic [2*BW-1:0] w_acc_nxt;
    logic [2*BW-1:0] w_prod;
    logic [BW:0]     w_prod_top;
    logic            w_mul_ovf;

    assign w_sh    = bus.in_b[c_sw-1:0];
    assign w_a_msb = bus.in_a[BW-1];
    assign w_b_msb = bus.in_b[BW-1];
    // -2^(BW-1) maps to 2^(BW-1), which still fits the unsigned BW-bit magnitude
    assign w_abs_a = w_a_msb ? (~bus.in_a + c_one) : bus.in_a;
    assign w_abs_b = w_b_msb ? (~bus.in_b + c_one) : bus.in_b;

    // Final step is folded into the finishing edge so CALC lasts exactly BW cycles
    assign w_acc_nxt  = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_prod     = r_sign ? -w_acc_nxt : w_acc_nxt;
    assign w_prod_top = w_prod[2*BW-1:BW-1];
    assign w_mul_ovf  = ~((&w_prod_top) | (~|w_prod_top));

    assign w_accept = (r_state == ST_IDLE) && r_live && bus.in_valid;

    // Single-cycle operations and their overflow, evaluated on the live operands
    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        case (bus.opcode)
            c_op_add: begin
                w_res = bus.in_a + bus.in_b;
                w_ovf = (w_a_msb == w_b_msb) && (w_res[BW-1] != w_a_msb);
            end
            c_op_sub: begin
                w_res = bus.in_a - bus.in_b;
                w_ovf = (w_a_msb != w_b_msb) && (w_res[BW-1] != w_a_msb);
            end
            c_op_and: w_res = bus.in_a & bus.in_b;
            c_op_or:  w_res = bus.in_a | bus.in_b;
            c_op_xor: w_res = bus.in_a ^ bus.in_b;
            c_op_not: w_res = ~bus.in_a;
            c_op_inc: begin
                w_res = bus.in_a + c_one;
                w_ovf = (bus.in_a == c_max_pos);
            end
            c_op_dec: begin
                w_res = bus.in_a - c_one;
                w_ovf = (bus.in_a == c_min_neg);
            end
            c_op_sll: w_res = bus.in_a << w_sh;
            c_op_srl: w_res = bus.in_a >> w_sh;
            c_op_sra: w_res = $signed(bus.in_a) >>> w_sh;
            default:  w_res = '0;  // MUL is handled iteratively; reserved gives 0
        endcase
    end

    // State register; r_live keeps in_ready low until the first edge after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_live  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_live  <= 1'b1;
        end
    end

    // Next-state and handshake decode from the state register
    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = r_live;
                if (w_accept) begin
                    w_next = (bus.opcode == c_op_mul) ? ST_CALC : ST_DONE;
                end
            end
            ST_CALC: begin
                if (r_cnt == c_cnt_last) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Operand capture, shift-add multiply steps and result/flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out    <= '0;
            r_flags  <= 3'b000;
            r_cnt    <= '0;
            r_sign   <= 1'b0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (w_accept) begin
            if (bus.opcode == c_op_mul) begin
                r_acc    <= '0;
                r_mcand  <= {{BW{1'b0}}, w_abs_a};
                r_mplier <= w_abs_b;
                r_sign   <= w_a_msb ^ w_b_msb;
                r_cnt    <= '0;
            end else begin
                r_out   <= w_res;
                r_flags <= {w_ovf, w_res[BW-1], (w_res == '0)};
            end
        end else if (r_state == ST_CALC) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + c_sw'(1);
            if (r_cnt == c_cnt_last) begin
                r_out   <= w_prod[BW-1:0];
                r_flags <= {w_mul_ovf, w_prod[BW-1], (w_prod[BW-1:0] == '0)};
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out       = r_out;
    assign bus.flags     = r_flags;
endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq
// Description : Self-checking bench for alu_seq: directed vector table,
//               multi-cycle corner sequences and randomized ops against an
//               integer-arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;
    localparam int BW = 16;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] eo;
        logic [2:0]  ef;
        int          elat;
    } vec_t;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;
    vec_t vecs[$];

    alu_seq_if #(.BW(BW)) bus ();

    alu_seq #(.BW(BW)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else n_pass++;
    endtask

    // Reference: exact integer arithmetic, overflow = result outside BW-bit signed range
    task automatic model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] o, output logic [2:0] f);
        longint sa;
        longint sb;
        longint full;
        logic   ovf;
        logic signed [15:0] s;
        int     sh;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        sh   = int'(b[3:0]);
        full = 0;
        ovf  = 1'b0;
        o    = 16'h0000;
        case (op)
            4'd0, 4'd1, 4'd6, 4'd7, 4'd11: begin
                case (op)
                    4'd0:    full = sa + sb;
                    4'd1:    full = sa - sb;
                    4'd6:    full = sa + 1;
                    4'd7:    full = sa - 1;
                    default: full = sa * sb;
                endcase
                o   = full[15:0];
                ovf = (full > 32767) || (full < -32768);
            end
            4'd2:  o = a & b;
            4'd3:  o = a | b;
            4'd4:  o = a ^ b;
            4'd5:  o = ~a;
            4'd8:  o = a << sh;
            4'd9:  o = a >> sh;
            4'd10: begin s = a; s = s >>> sh; o = s; end
            default: o = 16'h0000;
        endcase
        f = {ovf, o[15], (o == 16'h0000)};
    endtask

    // One full transaction: accept, latency, optional backpressure, transfer
    task automatic do_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] eo, input logic [2:0] ef, input int elat,
                         input int hold, input bit churn, input string tag);
        int n;
        int lat;
        n = 0;
        while (!bus.in_ready && n < 50) begin @(posedge clk); #1; n++; end
        chk({tag, " in_ready before accept"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.opcode   = op;
        bus.in_a     = a;
        bus.in_b     = b;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_a     = 16'($urandom);
        bus.in_b     = 16'($urandom);
        bus.opcode   = 4'($urandom);
        lat = 1;
        while (!bus.out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        chk({tag, " latency"}, 32'(lat), 32'(elat));
        chk({tag, " out"}, 32'(bus.out), 32'(eo));
        chk({tag, " flags"}, 32'(bus.flags), 32'(ef));
        for (int i = 0; i < hold; i++) begin
            if (churn) begin
                bus.in_valid = 1'($urandom);
                bus.in_a     = 16'($urandom);
                bus.in_b     = 16'($urandom);
                bus.opcode   = 4'($urandom);
            end
            @(posedge clk); #1;
            chk({tag, " hold out_valid"}, 32'(bus.out_valid), 32'd1);
            chk({tag, " hold in_ready"}, 32'(bus.in_ready), 32'd0);
            chk({tag, " hold out"}, 32'(bus.out), 32'(eo));
            chk({tag, " hold flags"}, 32'(bus.flags), 32'(ef));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk({tag, " post out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, " post in_ready"}, 32'(bus.in_ready), 32'd1);
        chk({tag, " post out retained"}, 32'(bus.out), 32'(eo));
    endtask

    task automatic add_vec(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] eo, input logic [2:0] ef, input int elat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.eo = eo; v.ef = ef; v.elat = elat;
        vecs.push_back(v);
    endtask

    initial begin
        logic [15:0] ro;
        logic [2:0]  rf;
        logic [15:0] ra;
        logic [15:0] rb;
        logic [3:0]  rop;
        logic [15:0] specials [5];
        bit          seen;

        n_pass  = 0;
        n_total = 0;
        specials[0] = 16'h7FFF; specials[1] = 16'h8000; specials[2] = 16'hFFFF;
        specials[3] = 16'h0000; specials[4] = 16'h0001;

        add_vec(4'd0,  16'h7FFF, 16'h0001, 16'h8000, 3'b110, 1);
        add_vec(4'd1,  16'h0005, 16'h0005, 16'h0000, 3'b001, 1);
        add_vec(4'd10, 16'h8000, 16'h0004, 16'hF800, 3'b010, 1);
        add_vec(4'd8,  16'h0001, 16'h000F, 16'h8000, 3'b010, 1);
        add_vec(4'd11, 16'hFFFD, 16'h0007, 16'hFFEB, 3'b010, 17);
        add_vec(4'd11, 16'h8000, 16'hFFFF, 16'h8000, 3'b110, 17);
        add_vec(4'd11, 16'h0100, 16'h0100, 16'h0000, 3'b101, 17);
        add_vec(4'd13, 16'h1234, 16'h5678, 16'h0000, 3'b001, 1);
        add_vec(4'd2,  16'hF0F0, 16'h0FF0, 16'h00F0, 3'b000, 1);
        add_vec(4'd3,  16'h0000, 16'h0000, 16'h0000, 3'b001, 1);
        add_vec(4'd4,  16'hFFFF, 16'h0001, 16'hFFFE, 3'b010, 1);
        add_vec(4'd5,  16'h0000, 16'h1234, 16'hFFFF, 3'b010, 1);
        add_vec(4'd6,  16'h7FFF, 16'h0000, 16'h8000, 3'b110, 1);
        add_vec(4'd7,  16'h8000, 16'h0000, 16'h7FFF, 3'b100, 1);
        add_vec(4'd9,  16'h8000, 16'h0004, 16'h0800, 3'b000, 1);
        add_vec(4'd1,  16'h8000, 16'h0001, 16'h7FFF, 3'b100, 1);
        add_vec(4'd11, 16'hFFFF, 16'hFFFF, 16'h0001, 3'b000, 17);
        add_vec(4'd11, 16'h0000, 16'h1234, 16'h0000, 3'b001, 17);
        add_vec(4'd0,  16'h1111, 16'h2222, 16'h3333, 3'b000, 1);

        bus.in_valid  = 1'b0;
        bus.in_a      = 16'h0000;
        bus.in_b      = 16'h0000;
        bus.opcode    = 4'd0;
        bus.out_ready = 1'b0;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset in_ready", 32'(bus.in_ready), 32'd0);
        chk("reset out", 32'(bus.out), 32'd0);
        chk("reset flags", 32'(bus.flags), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("in_ready after reset release", 32'(bus.in_ready), 32'd1);

        // Directed vector table
        foreach (vecs[i]) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].eo, vecs[i].ef,
                  vecs[i].elat, 0, 1'b0, $sformatf("vec%0d", i));
        end

        // Backpressure: ADD held 5 cycles while inputs churn
        do_op(4'd0, 16'h0102, 16'h0304, 16'h0406, 3'b000, 1, 5, 1'b1, "backpressure");
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen = 1'b1;
        end
        chk("backpressure no extra result", 32'(seen), 32'd0);

        // Reset in the 5th CALC cycle of a multiply aborts it
        bus.in_valid = 1'b1;
        bus.opcode   = 4'd11;
        bus.in_a     = 16'hFFFD;
        bus.in_b     = 16'h0007;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midmul rst out_valid", 32'(bus.out_valid), 32'd0);
        chk("midmul rst out", 32'(bus.out), 32'd0);
        chk("midmul rst flags", 32'(bus.flags), 32'd0);
        chk("midmul rst in_ready", 32'(bus.in_ready), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("midmul in_ready after release", 32'(bus.in_ready), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen = 1'b1;
        end
        chk("midmul aborted no result", 32'(seen), 32'd0);
        do_op(4'd0, 16'h0002, 16'h0003, 16'h0005, 3'b000, 1, 0, 1'b0, "add after abort");

        // Randomized ops against the reference model
        for (int i = 0; i < 150; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : 16'($urandom);
            rb  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : 16'($urandom);
            model(rop, ra, rb, ro, rf);
            do_op(rop, ra, rb, ro, rf, (rop == 4'd11) ? 17 : 1,
                  int'($urandom_range(0, 2)), 1'($urandom), $sformatf("rnd%0d op%0d", i, rop));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
